// File: rtl/spi_seg_pkg.sv
// Shared definitions for the SPI segment-display master: FSM state
// encoding, default timing parameters and the frame length constant.
package spi_seg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_e;

   localparam int DEF_CLK_DIV = 4;   // SCLK half-period in clk cycles
   localparam int DEF_CS_GAP  = 2;   // minimum cs_n-high cycles between frames
   localparam int FRAME_LEN   = 18;  // cs_n low time, in units of CLK_DIV

   // States during which the SCLK divider runs.
   function automatic logic div_active(input state_e s);
      return (s == SETUP) || (s == SHIFT) || (s == HOLD);
   endfunction

endpackage

// File: rtl/spi_seg_clkdiv.sv
// SCLK divider: while enabled, emits a one-cycle tick every CLK_DIV clk
// cycles, alternating between rise_tick and fall_tick (rise first).
// Counter and phase are cleared whenever the divider is disabled, so every
// frame starts from the same point.
module spi_seg_clkdiv
   import spi_seg_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic rise_tick,
   output logic fall_tick
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       phase_q, phase_d;
   logic       tick;

   // Next-state for the divider count and the rise/fall phase.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
      cnt_d   = '0;
      phase_d = 1'b0;
      tick    = en && (cnt_q == DIV_LAST);
      if (en) begin
         cnt_d   = tick ? 8'd0 : cnt_q + 8'd1;
         phase_d = tick ? ~phase_q : phase_q;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together from pre-edge values.
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign rise_tick = tick && !phase_q;
   assign fall_tick = tick &&  phase_q;

endmodule

// File: rtl/spi_segment_master.sv
// SPI mode-0 master that sends one byte per frame to a segment-display
// controller. Frame: SETUP (CLK_DIV), 8 SCLK periods, HOLD (CLK_DIV), then
// CS_GAP cycles with cs_n high before returning to IDLE.
// Optional readback is enabled by defining SPI_SEG_READBACK_EN; without it
// miso is ignored and rx_data/rx_valid are held at zero.
module spi_segment_master
   import spi_seg_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int CS_GAP  = DEF_CS_GAP
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       sclk,
   output logic       mosi,
   output logic       cs_n,
   input  logic       miso,
   output logic [7:0] rx_data,
   output logic       rx_valid
);

   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

   state_e     state_q, state_d;
   logic [6:0] rem_q, rem_d;          // bits still to send after the current one
   logic [2:0] bit_cnt_q, bit_cnt_d;  // falling edges seen so far
   logic       last_bit_q, last_bit_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       cs_n_q, cs_n_d;
   logic       tx_ready_q, tx_ready_d;
   logic       busy_q, busy_d;
   logic       rise_tick, fall_tick;

   spi_seg_clkdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_clkdiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (div_active(state_q)),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   // Frame sequencing: next state and next values of all registered outputs.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      bit_cnt_d  = bit_cnt_q;
      last_bit_d = last_bit_q;
      gap_cnt_d  = gap_cnt_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      tx_ready_d = tx_ready_q;
      busy_d     = busy_q;
      unique case (state_q)
         IDLE: begin
            if (tx_valid && tx_ready_q) begin
               state_d    = SETUP;
               rem_d      = tx_data[6:0];
               mosi_d     = tx_data[7];
               cs_n_d     = 1'b0;
               sclk_d     = 1'b0;
               bit_cnt_d  = '0;
               last_bit_d = 1'b0;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         SETUP: begin
            if (rise_tick) begin
               state_d = SHIFT;
               sclk_d  = 1'b1;
            end
         end
         SHIFT: begin
            if (fall_tick) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == 3'd7) begin
                  // Eighth falling edge: bit 0 stays on mosi through HOLD.
                  last_bit_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  mosi_d    = rem_q[6];
                  rem_d     = {rem_q[5:0], 1'b0};
               end
            end else if (rise_tick) begin
               if (last_bit_q) begin
                  state_d = HOLD;
               end else begin
                  sclk_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (fall_tick) begin
               state_d   = GAP;
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               gap_cnt_d = '0;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d    = IDLE;
               tx_ready_d = 1'b1;
               busy_d     = 1'b0;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and output registers; reset aborts any frame immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shift and count registers are reset too, so an aborted frame leaves nothing behind.
         state_q    <= IDLE;
         rem_q      <= '0;
         bit_cnt_q  <= '0;
         last_bit_q <= 1'b0;
         gap_cnt_q  <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         bit_cnt_q  <= bit_cnt_d;
         last_bit_q <= last_bit_d;
         gap_cnt_q  <= gap_cnt_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;

`ifdef SPI_SEG_READBACK_EN
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;

   // Sample miso on each SCLK rise; publish the byte as cs_n rises.
   always_comb begin
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      if (sclk_d && !sclk_q) begin
         rx_shift_d = {rx_shift_q[6:0], miso};
      end
      if (cs_n_d && !cs_n_q) begin
         rx_data_d  = rx_shift_q;
         rx_valid_d = 1'b1;
      end
   end

   // Readback registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
`else
   logic unused_miso;
   assign unused_miso = miso;
   assign rx_data     = 8'h00;
   assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_segment_master.sv
// Testbench for spi_segment_master. A bus monitor turns the SPI pins into
// per-frame records; these are compared with what each submitted byte should
// produce (bits MSB first, 8 rises, 18*CLK_DIV low cycles, GAP length,
// frame period, readback byte). A second instance runs with CLK_DIV=1.
// Honours SPI_SEG_READBACK_EN for the readback expectations.
module tb_spi_segment_master;
   import spi_seg_pkg::*;

`ifdef SPI_SEG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   localparam int D = 4;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       miso = 1'b0;
   logic       tx_ready, busy, sclk, mosi, cs_n, rx_valid;
   logic [7:0] rx_data;

   logic [7:0] tx1_data = '0;
   logic       tx1_valid = 1'b0;
   logic       miso1 = 1'b0;
   logic       tx1_ready, busy1, sclk1, mosi1, cs1_n, rx1_valid;
   logic [7:0] rx1_data;

   spi_segment_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid)
   );

   spi_segment_master #(.CLK_DIV(1), .CS_GAP(G)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx1_data), .tx_valid(tx1_valid),
      .tx_ready(tx1_ready), .busy(busy1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs1_n),
      .miso(miso1), .rx_data(rx1_data), .rx_valid(rx1_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] bits;
      int         rises;
      int         low;
      int         viol;
      int         fall_cyc;
      logic       rxv;
      logic [7:0] rxd;
   } frame_t;

   frame_t     frames[$];
   int         gaps[$];
   logic [7:0] miso_q[$];
   logic [7:0] exp_data[$];
   logic [7:0] exp_miso[$];

   int checks = 0;
   int errors = 0;

   int         cyc = 0;
   int         cur_rises = 0, cur_low = 0, cur_viol = 0, cur_fall = 0, mi = 0;
   logic [7:0] cur_bits = '0, cur_miso = '0;
   logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
   int         gapc = 0, rxv_cnt = 0, rx_nz = 0, idle_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor for dut: samples on the falling clk edge, plays a mode-0
   // slave on miso, and records every completed frame.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         miso1 = ~miso1;
         if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
            cur_rises = 0; gapc = 0; miso = 1'b0;
         end else begin
            if (rx_valid === 1'b1) rxv_cnt++;
            if (rx_data !== 8'h00 || rx_valid !== 1'b0) rx_nz++;
            if (cs_n === 1'b0) begin
               if (prev_cs) begin
                  cur_bits = '0; cur_rises = 0; cur_low = 0; cur_viol = 0; cur_fall = cyc;
                  cur_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
                  mi = 7;
                  miso = cur_miso[7];
               end else if (mosi !== prev_mosi && !(prev_sclk && !sclk)) begin
                  cur_viol++;
               end
               cur_low++;
               if (sclk && !prev_sclk) begin
                  cur_rises++;
                  cur_bits = {cur_bits[6:0], mosi};
               end
               if (!sclk && prev_sclk && mi > 0) begin
                  mi--;
                  miso = cur_miso[mi];
               end
            end else begin
               if (!prev_cs) begin
                  frames.push_back('{cur_bits, cur_rises, cur_low, cur_viol, cur_fall, rx_valid, rx_data});
                  cur_rises = 0;
               end
               if (sclk !== 1'b0 || mosi !== 1'b0) idle_bad++;
               if (busy) gapc++;
               else if (gapc > 0) begin
                  gaps.push_back(gapc);
                  gapc = 0;
               end
            end
            prev_cs = cs_n; prev_sclk = sclk; prev_mosi = mosi;
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic [7:0] m, input bit completes);
      int n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      miso_q.push_back(m);
      if (completes) begin
         exp_data.push_back(b);
         exp_miso.push_back(m);
      end
      while (!tx_ready && n < 2000) begin
         @(posedge clk); #2;
         n++;
      end
      check("accept_wait", (n < 2000) ? 1 : 0, 1);
      @(posedge clk); #2;
      check("busy_after_accept", busy, 1'b1);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((frames.size() < exp_data.size() || busy) && n < 3000) begin
         @(posedge clk); #2;
         n++;
      end
      check("done_wait", (n < 3000) ? 1 : 0, 1);
   endtask

   initial begin
      int         base, nfr, nrx, n, low1, rises1;
      logic [7:0] bits1, b, m;
      logic       ps1;

      // Reset values while rst_n is held low.
      #12;
      check("reset_pins", {sclk, cs_n, mosi, tx_ready, busy, rx_valid}, 6'b010100);
      check("reset_rx_data", rx_data, 8'h00);
      @(posedge clk); #2;
      rst_n = 1'b1;

      // CLK_DIV=1 instance: 8'h80, accepted on the first edge after reset.
      tx1_data  = 8'h80;
      tx1_valid = 1'b1;
      @(posedge clk); #2;
      check("d1_first_edge_accept", busy1, 1'b1);
      tx1_valid = 1'b0;
      tx1_data  = 8'($urandom);
      low1 = 0; rises1 = 0; bits1 = '0; ps1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!cs1_n) low1++;
         if (sclk1 && !ps1) begin
            rises1++;
            bits1 = {bits1[6:0], mosi1};
         end
         ps1 = sclk1;
      end
      check("d1_cs_low", low1, FRAME_LEN);
      check("d1_rises", rises1, 8);
      check("d1_bits", bits1, 8'h80);
      if (!RB) check("d1_rx_zero", {rx1_valid, rx1_data}, 9'h000);
      check("d1_idle", {tx1_ready, busy1, cs1_n}, 3'b101);

      // Single frame 8'hA5.
      @(posedge clk); #2;
      send(8'hA5, 8'($urandom), 1'b1);
      wait_done();

      // Back-to-back 8'h3F then 8'h06 with tx_valid held high.
      base = frames.size();
      send(8'h3F, 8'($urandom), 1'b1);
      send(8'h06, 8'($urandom), 1'b1);
      wait_done();
      if (frames.size() >= base + 2)
         check("b2b_period", frames[base+1].fall_cyc - frames[base].fall_cyc, FRAME_LEN*D + G + 1);
      else
         check("b2b_frames", frames.size(), base + 2);

      // Reset after the third SCLK rise aborts the frame.
      send(8'h5A, 8'($urandom), 1'b0);
      n = 0;
      while (cur_rises < 3 && n < 500) begin
         @(posedge clk); #2;
         n++;
      end
      check("rise3_wait", (n < 500) ? 1 : 0, 1);
      nfr = frames.size();
      nrx = rxv_cnt;
      rst_n = 1'b0;
      #1;
      check("abort_pins", {cs_n, sclk, busy, tx_ready, mosi, rx_valid}, 6'b100100);
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      check("abort_no_frame", frames.size(), nfr);
      check("abort_no_rx_valid", rxv_cnt, nrx);
      send(8'hFF, 8'($urandom), 1'b1);
      wait_done();

      // Randomized bytes, some back-to-back, some after idle time.
      for (int k = 0; k < 5; k++) begin
         b = 8'($urandom);
         m = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #2;
         end
         send(b, m, 1'b1);
      end
      wait_done();

      // Readback byte 8'hC3.
      send(8'($urandom), 8'hC3, 1'b1);
      wait_done();

      // Long idle with tx_valid low.
      repeat (50) @(posedge clk);
      #2;
      check("idle_ready", {tx_ready, busy, cs_n, sclk}, 4'b1010);

      // Compare every recorded frame with the expected behaviour.
      check("frame_count", frames.size(), exp_data.size());
      for (int i = 0; i < frames.size() && i < exp_data.size(); i++) begin
         check($sformatf("f%0d_bits", i), frames[i].bits, exp_data[i]);
         check($sformatf("f%0d_rises", i), frames[i].rises, 8);
         check($sformatf("f%0d_cs_low", i), frames[i].low, FRAME_LEN*D);
         check($sformatf("f%0d_mosi_stable", i), frames[i].viol, 0);
         check($sformatf("f%0d_rx_valid", i), frames[i].rxv, RB);
         check($sformatf("f%0d_rx_data", i), frames[i].rxd, RB ? exp_miso[i] : 8'h00);
      end
      check("gap_count", gaps.size(), frames.size());
      for (int i = 0; i < gaps.size(); i++)
         check($sformatf("gap%0d_len", i), gaps[i], G);
      check("rx_valid_total", rxv_cnt, RB ? frames.size() : 0);
      if (!RB) check("rx_always_zero", rx_nz, 0);
      check("idle_pins_quiet", idle_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
